traffic_light_fsm: RTL and testbench

Main/side-street traffic light sequencer that consumes the registered sensor, walk and reprogram strobes from the input synchronizer stage. Runs a phase state machine timed by a shared 1 Hz enable tick, with run-time programmable interval registers. Drives the main lights, side lights and walk lamp, and pulses a walk-request acknowledge.

---
 rtl/traffic_light_fsm.sv | 178 +++++++++++++++++
 tb/tb_traffic_light_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Main/side-street traffic light sequencer: phase FSM timed by a shared 1 Hz tick,
// with run-time programmable base/extended/yellow intervals and a latched walk request.
module traffic_light_fsm #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             sensor_sync,
  input  logic             wr_sync,
  input  logic             prog_sync,
  input  logic [1:0]       time_sel,
  input  logic [CNT_W-1:0] time_val,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk_light,
  output logic             wr_ack,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    SG1  = 3'd3,
    SG2  = 3'd4,
    SY   = 3'd5,
    WALK = 3'd6
  } state_t;

  localparam logic [2:0]       LT_R     = 3'b100;
  localparam logic [2:0]       LT_Y     = 3'b010;
  localparam logic [2:0]       LT_G     = 3'b001;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_BASE = CNT_W'(T_BASE);
  localparam logic [CNT_W-1:0] RST_EXT  = CNT_W'(T_EXT);
  localparam logic [CNT_W-1:0] RST_YEL  = CNT_W'(T_YEL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;
  logic [CNT_W-1:0] prog_val;
  logic             walk_req_q, walk_req_d;
  logic             enter_walk;
  logic             expire;
  logic [2:0]       main_d, side_d;
  logic             walk_d;

  assign state = state_q;

  // Next-state, timer reload, interval programming and walk-request latch.
  // The walk request is a level latched on wr_sync and served (wr_ack) on WALK entry.
  always_comb begin
    base_d     = base_q;
    ext_d      = ext_q;
    yel_d      = yel_q;
    state_d    = state_q;
    timer_d    = timer_q;
    walk_req_d = walk_req_q | wr_sync;
    enter_walk = 1'b0;
    expire     = tick && (timer_q == '0);
    prog_val   = (time_val == '0) ? ONE : time_val;

    if (prog_sync) begin
      case (time_sel)
        2'b00:   base_d = prog_val;
        2'b01:   ext_d  = prog_val;
        2'b10:   yel_d  = prog_val;
        default: ;
      endcase
      state_d    = MG1;
      timer_d    = base_d - ONE;
      walk_req_d = 1'b0;
    end else begin
      if (tick && (timer_q != '0)) timer_d = timer_q - ONE;
      // Each reload is interval-1 so a phase spans exactly its interval in ticks.
      case (state_q)
        MG1: if (expire) begin
          state_d = MG2;
          timer_d = (sensor_sync ? ext_q : base_q) - ONE;
        end
        MG2: if (expire) begin
          state_d = MY;
          timer_d = yel_q - ONE;
        end
        MY: if (expire) begin
          state_d = SG1;
          timer_d = base_q - ONE;
        end
        SG1: if (expire) begin
          if (sensor_sync) begin
            state_d = SG2;
            timer_d = ext_q - ONE;
          end else begin
            state_d = SY;
            timer_d = yel_q - ONE;
          end
        end
        SG2: if (expire) begin
          state_d = SY;
          timer_d = yel_q - ONE;
        end
        SY: if (expire) begin
          if (walk_req_q) begin
            state_d    = WALK;
            timer_d    = ext_q - ONE;
            enter_walk = 1'b1;
          end else begin
            state_d = MG1;
            timer_d = base_q - ONE;
          end
        end
        WALK: if (expire) begin
          state_d = MG1;
          timer_d = base_q - ONE;
        end
        default: begin
          state_d = MG1;
          timer_d = base_q - ONE;
        end
      endcase
      if (enter_walk) walk_req_d = 1'b0;
    end
  end

  always_comb begin
    main_d = LT_G;
    side_d = LT_R;
    walk_d = 1'b0;
    case (state_q)
      MY: main_d = LT_Y;
      SG1, SG2: begin
        main_d = LT_R;
        side_d = LT_G;
      end
      SY: begin
        main_d = LT_R;
        side_d = LT_Y;
      end
      WALK: begin
        main_d = LT_R;
        side_d = LT_R;
        walk_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MG1;
      timer_q    <= RST_BASE - ONE;
      base_q     <= RST_BASE;
      ext_q      <= RST_EXT;
      yel_q      <= RST_YEL;
      walk_req_q <= 1'b0;
      main_light <= LT_G;
      side_light <= LT_R;
      walk_light <= 1'b0;
      wr_ack     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      base_q     <= base_d;
      ext_q      <= ext_d;
      yel_q      <= yel_d;
      walk_req_q <= walk_req_d;
      main_light <= main_d;
      side_light <= side_d;
      walk_light <= walk_d;
      wr_ack     <= enter_walk;
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase table with per-phase tick durations and lights,
// plus hand-written reprogram and asynchronous reset sequences.
module tb_traffic_light_fsm;

  localparam int CNT_W = 4;
  localparam logic [2:0] S_MG1 = 3'd0, S_MG2 = 3'd1, S_MY = 3'd2, S_SG1 = 3'd3,
                         S_SG2 = 3'd4, S_SY = 3'd5, S_WALK = 3'd6;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;

  typedef struct {
    logic       sensor;
    logic [1:0] wr;      // 0 none, 1 one-cycle pulse at phase start, 2 held for the phase
    logic [2:0] st;
    int         ticks;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    int         acks;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             sensor_sync;
  logic             wr_sync;
  logic             prog_sync;
  logic [1:0]       time_sel;
  logic [CNT_W-1:0] time_val;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             walk_light;
  logic             wr_ack;
  logic [2:0]       state;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   div_cnt  = 0;
  logic tick_seen;
  logic [6:0] exp_q[$];
  vec_t vecs[30];

  always #5 clk = ~clk;

  traffic_light_fsm #(.T_BASE(6), .T_EXT(3), .T_YEL(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .sensor_sync(sensor_sync),
    .wr_sync    (wr_sync),
    .prog_sync  (prog_sync),
    .time_sel   (time_sel),
    .time_val   (time_val),
    .main_light (main_light),
    .side_light (side_light),
    .walk_light (walk_light),
    .wr_ack     (wr_ack),
    .state      (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: tick is asserted on every fourth edge.
  task automatic step();
    tick = (div_cnt == 3);
    @(posedge clk);
    #1;
    tick_seen = tick;
    div_cnt   = (div_cnt + 1) % 4;
  endtask

  function automatic vec_t mk(input logic [2:0] st, input int ticks, input logic sensor,
                              input logic [1:0] wr, input int acks);
    vec_t v;
    v.st = st; v.ticks = ticks; v.sensor = sensor; v.wr = wr; v.acks = acks;
    v.walk = 1'b0;
    case (st)
      S_MG1, S_MG2: begin v.main = L_G; v.side = L_R; end
      S_MY:         begin v.main = L_Y; v.side = L_R; end
      S_SG1, S_SG2: begin v.main = L_R; v.side = L_G; end
      S_SY:         begin v.main = L_R; v.side = L_Y; end
      default:      begin v.main = L_R; v.side = L_R; v.walk = 1'b1; end
    endcase
    return v;
  endfunction

  // Called just after the edge that entered the phase; returns just after the edge that left it.
  task automatic run_phase(input vec_t v, input string tag);
    int n;
    int cyc;
    int acks;
    logic [6:0] e;
    sensor_sync = v.sensor;
    chk({tag, " state"}, 32'(state), 32'(v.st));
    exp_q.push_back({v.main, v.side, v.walk});
    acks = wr_ack ? 1 : 0;
    n    = 0;
    cyc  = 0;
    do begin
      wr_sync = (v.wr == 2'd2) || (v.wr == 2'd1 && cyc == 0);
      step();
      cyc++;
      if (tick_seen) n++;
      if (cyc == 1) begin
        e = exp_q.pop_front();
        chk({tag, " lights"}, 32'({main_light, side_light, walk_light}), 32'(e));
      end
      if (state == v.st && wr_ack) acks++;
    end while (state == v.st && cyc < 100);
    wr_sync = 1'b0;
    if (cyc >= 100) chk({tag, " timeout"}, 32'(cyc), 32'(99));
    chk({tag, " ticks"}, 32'(n), 32'(v.ticks));
    chk({tag, " acks"}, 32'(acks), 32'(v.acks));
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int cyc = 0;
    while (state != s && cyc < 400) begin
      step();
      cyc++;
    end
    chk({tag, " reached"}, 32'(state), 32'(s));
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; sensor_sync = 1'b0; wr_sync = 1'b0;
    prog_sync = 1'b0; time_sel = 2'b11; time_val = '0;

    // Default cycle, sensor idle
    vecs[0]  = mk(S_MG1, 6, 0, 0, 0);
    vecs[1]  = mk(S_MG2, 6, 0, 0, 0);
    vecs[2]  = mk(S_MY,  2, 0, 0, 0);
    vecs[3]  = mk(S_SG1, 6, 0, 0, 0);
    vecs[4]  = mk(S_SY,  2, 0, 0, 0);
    // Sensor held: extended MG2 and SG2
    vecs[5]  = mk(S_MG1, 6, 1, 0, 0);
    vecs[6]  = mk(S_MG2, 3, 1, 0, 0);
    vecs[7]  = mk(S_MY,  2, 1, 0, 0);
    vecs[8]  = mk(S_SG1, 6, 1, 0, 0);
    vecs[9]  = mk(S_SG2, 3, 1, 0, 0);
    vecs[10] = mk(S_SY,  2, 1, 0, 0);
    // Walk pulse during MG1
    vecs[11] = mk(S_MG1, 6, 0, 1, 0);
    vecs[12] = mk(S_MG2, 6, 0, 0, 0);
    vecs[13] = mk(S_MY,  2, 0, 0, 0);
    vecs[14] = mk(S_SG1, 6, 0, 0, 0);
    vecs[15] = mk(S_SY,  2, 0, 0, 0);
    vecs[16] = mk(S_WALK, 3, 0, 0, 1);
    // Walk request held across WALK entry re-latches
    vecs[17] = mk(S_MG1, 6, 0, 0, 0);
    vecs[18] = mk(S_MG2, 6, 0, 0, 0);
    vecs[19] = mk(S_MY,  2, 0, 0, 0);
    vecs[20] = mk(S_SG1, 6, 0, 0, 0);
    vecs[21] = mk(S_SY,  2, 0, 2, 0);
    vecs[22] = mk(S_WALK, 3, 0, 2, 1);
    vecs[23] = mk(S_MG1, 6, 0, 0, 0);
    vecs[24] = mk(S_MG2, 6, 0, 0, 0);
    vecs[25] = mk(S_MY,  2, 0, 0, 0);
    vecs[26] = mk(S_SG1, 6, 0, 0, 0);
    vecs[27] = mk(S_SY,  2, 0, 0, 0);
    vecs[28] = mk(S_WALK, 3, 0, 0, 1);
    vecs[29] = mk(S_MG1, 6, 0, 0, 0);

    step();
    step();
    chk("reset state", 32'(state), 32'(S_MG1));
    chk("reset main", 32'(main_light), 32'(L_G));
    chk("reset side", 32'(side_light), 32'(L_R));
    chk("reset walk", 32'(walk_light), 32'(0));
    chk("reset ack", 32'(wr_ack), 32'(0));
    reset = 1'b1;

    for (int i = 0; i < 30; i++) run_phase(vecs[i], $sformatf("vec%0d", i));

    // Reprogram base to 0 (stored as 1) during MY, on a tick cycle, with a walk request pending
    wait_state(S_MY, "prog my");
    wr_sync = 1'b1;
    step();
    wr_sync = 1'b0;
    while (div_cnt != 3) step();
    prog_sync = 1'b1; time_sel = 2'b00; time_val = '0;
    step();
    prog_sync = 1'b0; time_sel = 2'b11;
    chk("prog state", 32'(state), 32'(S_MG1));
    run_phase(mk(S_MG1, 1, 0, 0, 0), "prog mg1");
    run_phase(mk(S_MG2, 1, 0, 0, 0), "prog mg2");
    run_phase(mk(S_MY,  2, 0, 0, 0), "prog my2");
    run_phase(mk(S_SG1, 1, 0, 0, 0), "prog sg1");
    run_phase(mk(S_SY,  2, 0, 0, 0), "prog sy");
    run_phase(mk(S_MG1, 1, 0, 0, 0), "prog nowalk");

    // Asynchronous reset in the middle of SG2
    sensor_sync = 1'b1;
    wait_state(S_SG2, "arst sg2");
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst state", 32'(state), 32'(S_MG1));
    chk("arst main", 32'(main_light), 32'(L_G));
    chk("arst side", 32'(side_light), 32'(L_R));
    chk("arst walk", 32'(walk_light), 32'(0));
    chk("arst ack", 32'(wr_ack), 32'(0));
    step();
    step();
    reset = 1'b1;
    run_phase(mk(S_MG1, 6, 1, 0, 0), "arst mg1");
    run_phase(mk(S_MG2, 3, 1, 0, 0), "arst mg2");
    run_phase(mk(S_MY,  2, 1, 0, 0), "arst my");
    run_phase(mk(S_SG1, 6, 1, 0, 0), "arst sg1");
    run_phase(mk(S_SG2, 3, 1, 0, 0), "arst sg2b");
    run_phase(mk(S_SY,  2, 1, 0, 0), "arst sy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
